// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM for an RGB LED; duties only change at period wraps so no runt pulses.
// Define RGB_PWM_FADE_EN to make each duty step by one toward its target per period instead of jumping.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 195
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       enable,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic [7:0] red_duty,
  output logic [7:0] green_duty,
  output logic [7:0] blue_duty,
  output logic       period_start
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre;
  logic [7:0]  cnt;
  logic        tick;
  logic        wrap;
  logic [7:0]  red_nxt;
  logic [7:0]  green_nxt;
  logic [7:0]  blue_nxt;

  assign tick = (pre == PRE_LAST);
  assign wrap = tick && (cnt == 8'hFF);

  // Gated by enable so a disable landing on the wrap cycle suppresses the pulse.
  assign period_start = enable && wrap;

`ifdef RGB_PWM_FADE_EN
  function automatic logic [7:0] fade_step(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end
    return cur;
  endfunction

  assign red_nxt   = fade_step(red_duty, red_in);
  assign green_nxt = fade_step(green_duty, green_in);
  assign blue_nxt  = fade_step(blue_duty, blue_in);
`else
  assign red_nxt   = red_in;
  assign green_nxt = green_in;
  assign blue_nxt  = blue_in;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (!enable) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 8'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // While stopped the duties track software directly so readback reflects writes.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      red_duty   <= '0;
      green_duty <= '0;
      blue_duty  <= '0;
    end else if (!enable) begin
      red_duty   <= red_in;
      green_duty <= green_in;
      blue_duty  <= blue_in;
    end else if (wrap) begin
      red_duty   <= red_nxt;
      green_duty <= green_nxt;
      blue_duty  <= blue_nxt;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      pwm_r <= enable && (cnt < red_duty);
      pwm_g <= enable && (cnt < green_duty);
      pwm_b <= enable && (cnt < blue_duty);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: period-position reference model checked every cycle, plus directed literal checks.
module tb_rgb_pwm_driver;
  localparam int P   = 3;
  localparam int PER = 256 * P;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] red_in = 8'h00;
  logic [7:0] green_in = 8'h00;
  logic [7:0] blue_in = 8'h00;
  logic       pwm_r, pwm_g, pwm_b;
  logic [7:0] red_duty, green_duty, blue_duty;
  logic       period_start;

  int vectors = 0;
  int errors  = 0;
  bit chk_on  = 1'b0;

  rgb_pwm_driver #(.PRESCALE(P)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .red_duty(red_duty), .green_duty(green_duty), .blue_duty(blue_duty),
    .period_start(period_start)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period is just the count of enabled cycles.
  int         m_t;
  logic [7:0] m_duty [3];
  logic       m_pwm  [3];

`ifdef RGB_PWM_FADE_EN
  function automatic logic [7:0] fade_to(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur == tgt) return cur;
    return (cur < tgt) ? cur + 8'd1 : cur - 8'd1;
  endfunction
`endif

  always @(posedge clk_clk) begin
    logic [7:0] tin [3];
    int         pos_cnt;
    bit         at_wrap;
    tin = '{red_in, green_in, blue_in};
    if (!reset_reset_n) begin
      m_t = 0;
      for (int i = 0; i < 3; i++) begin
        m_duty[i] = 8'h00;
        m_pwm[i]  = 1'b0;
      end
    end else begin
      pos_cnt = (m_t / P) % 256;
      at_wrap = enable && (m_t == PER - 1);
      for (int i = 0; i < 3; i++) begin
        m_pwm[i] = enable && (pos_cnt < int'(m_duty[i]));
        if (!enable) begin
          m_duty[i] = tin[i];
        end else if (at_wrap) begin
`ifdef RGB_PWM_FADE_EN
          m_duty[i] = fade_to(m_duty[i], tin[i]);
`else
          m_duty[i] = tin[i];
`endif
        end
      end
      m_t = enable ? (m_t + 1) % PER : 0;
    end
    #1;
    if (chk_on) begin
      check("model_pwm_r", pwm_r, m_pwm[0]);
      check("model_pwm_g", pwm_g, m_pwm[1]);
      check("model_pwm_b", pwm_b, m_pwm[2]);
      check("model_red_duty", red_duty, m_duty[0]);
      check("model_green_duty", green_duty, m_duty[1]);
      check("model_blue_duty", blue_duty, m_duty[2]);
      check("model_period_start", period_start,
            reset_reset_n && enable && (m_t == PER - 1));
    end
  end

  // Returns in the cycle carrying a period_start pulse; n = clock edges waited.
  task automatic wait_ps(output int n);
    n = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      @(posedge clk_clk); #1;
      n++;
      if (period_start) return;
    end
    check("period_start_timeout", 0, 1);
  endtask

  initial begin
    int n, hr, hg, hb, h1, h2;
    chk_on = 1'b1;
    @(posedge clk_clk); #2;
    check("rst_pwm_r", pwm_r, 0);
    check("rst_pwm_g", pwm_g, 0);
    check("rst_pwm_b", pwm_b, 0);
    check("rst_red_duty", red_duty, 0);
    check("rst_period_start", period_start, 0);

    @(negedge clk_clk); reset_reset_n = 1'b1; red_in = 8'h33;
    @(posedge clk_clk); #1;
    check("dis_duty_track", red_duty, 8'h33);
    check("dis_pwm_low", pwm_r, 0);

`ifndef RGB_PWM_FADE_EN
    // Duty extremes over the first period after enable rises.
    @(negedge clk_clk); red_in = 8'h00; green_in = 8'hFF; blue_in = 8'h80;
    @(negedge clk_clk); enable = 1'b1;
    hr = 0; hg = 0; hb = 0;
    for (int k = 1; k <= PER; k++) begin
      @(posedge clk_clk); #1;
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
      if (k == 1)   check("first_run_g_starts", pwm_g, 1);
      if (k == 384) check("b_last_high", pwm_b, 1);
      if (k == 385) check("b_first_low", pwm_b, 0);
      if (k == PER - 1) check("first_wrap_pulse", period_start, 1);
    end
    check("high_r_0x00", hr, 0);
    check("high_g_0xff", hg, 255 * P);
    check("high_b_0x80", hb, 128 * P);

    wait_ps(n); check("ps_gap_first", n, PER - 1);
    wait_ps(n); check("ps_gap_full", n, PER);

    // Write landing on the wrap cycle is the one loaded.
    @(negedge clk_clk); red_in = 8'h40;
    @(posedge clk_clk); #1;
    check("wrap_cycle_load", red_duty, 8'h40);
    h1 = 0; h2 = 0;
    for (int k = 1; k <= 2 * PER; k++) begin
      @(posedge clk_clk); #1;
      if (k <= PER) h1 += int'(pwm_r); else h2 += int'(pwm_r);
      if (k == 100) check("mid_write_duty_held", red_duty, 8'h40);
      if (k == PER) check("mid_write_duty_new", red_duty, 8'hC0);
      if (k == 48) begin
        @(negedge clk_clk); red_in = 8'hC0;
      end
    end
    check("mid_write_old_period", h1, 8'h40 * P);
    check("mid_write_new_period", h2, 8'hC0 * P);

    // Drop enable at cnt 0x50.
    repeat (80 * P) @(posedge clk_clk);
    #1; check("pre_disable_g_high", pwm_g, 1);
    @(negedge clk_clk); enable = 1'b0; red_in = 8'h11;
    @(posedge clk_clk); #1;
    check("disable_pwm_r", pwm_r, 0);
    check("disable_pwm_g", pwm_g, 0);
    check("disable_pwm_b", pwm_b, 0);
    check("disable_duty_track", red_duty, 8'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk); red_in = 8'h20 + 8'(i);
      @(posedge clk_clk); #1;
      check("disable_duty_follow", red_duty, 8'h20 + i);
    end
    @(negedge clk_clk); enable = 1'b1;
    @(posedge clk_clk); #1;
    check("reenable_g_high", pwm_g, 1);
    check("reenable_duty", red_duty, 8'h22);
    wait_ps(n); check("reenable_first_pulse", n, PER - 2);

    // Asynchronous reset mid-period.
    repeat (100) @(posedge clk_clk);
    #2; reset_reset_n = 1'b0;
    #1;
    check("async_rst_pwm_g", pwm_g, 0);
    check("async_rst_green_duty", green_duty, 0);
    check("async_rst_red_duty", red_duty, 0);
    check("async_rst_period_start", period_start, 0);
    @(negedge clk_clk); enable = 1'b0;
    @(negedge clk_clk); reset_reset_n = 1'b1;
    repeat (5) @(posedge clk_clk);
    #1; check("post_rst_pwm_g_low", pwm_g, 0);
    @(negedge clk_clk); enable = 1'b1;
`else
    // Fade: green steps 0 -> 5 one count per wrap, then holds.
    @(negedge clk_clk); green_in = 8'h00;
    @(negedge clk_clk); enable = 1'b1;
    @(negedge clk_clk); green_in = 8'h05;
    for (int i = 1; i <= 6; i++) begin
      wait_ps(n);
      @(posedge clk_clk); #1;
      check("fade_green_step", green_duty, (i < 5) ? i : 5);
    end
`endif

    // Randomised traffic checked by the model.
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk_clk);
      if ($urandom_range(39) == 0) begin
        logic [7:0] v;
        v = ($urandom_range(3) == 0) ? ($urandom_range(1) ? 8'hFF : 8'h00) : 8'($urandom);
        case ($urandom_range(2))
          0: red_in = v;
          1: green_in = v;
          default: blue_in = v;
        endcase
      end
      if (enable && $urandom_range(2499) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(19) == 0) enable = 1'b1;
    end

    @(posedge clk_clk); #2;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
